// File: rtl/seg_display_mux.sv
// Multiplexed common-anode seven-segment driver with blink, dp, hex/BCD decode, LZ blanking, PWM and alarm LEDs.
// All outputs registered, one cycle after sel/inputs/counters; free-running, no backpressure.
module seg_display_mux #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 32768,
    parameter int BLINK_HALF = 16777216,
    parameter int PWM_BITS   = 4,
    parameter int LED_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blink_i,
    input  logic                  hex_mode_i,
    input  logic                  lzb_i,
    input  logic [PWM_BITS-1:0]   bright_i,
    input  logic                  alarm_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [LED_W-1:0]      led_o,
    output logic                  blink_phase_o,
    output logic                  scan_tick_o
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_HALF);
    localparam int SEL_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(DIGITS - 1);
    localparam logic [LED_W-1:0]   LED_A      = {(LED_W/2){2'b10}};
    localparam logic [LED_W-1:0]   LED_B      = {(LED_W/2){2'b01}};
    localparam logic [6:0]         SEG_OFF    = 7'b1111111;

    logic [SCAN_W-1:0]   scan_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SEL_W-1:0]    sel;
    logic                blink_phase;

    logic                scan_end;
    logic                blink_end;
    logic [3:0]          nibble;
    logic [DIGITS:0]     lz_run;
    logic                lz_blank;
    logic                dark;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (!hex && v > 4'd9) begin
            s = 7'b1111111;
        end
        return s;
    endfunction

    assign scan_end      = (scan_cnt == SCAN_LAST);
    assign blink_end     = (blink_cnt == BLINK_LAST);
    assign blink_phase_o = blink_phase;

    // Scan, blink and PWM timebases; each wraps independently
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            sel         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
        end else begin
            if (scan_end) begin
                scan_cnt <= '0;
                sel      <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (blink_end) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // lz_run[k] is set when nibbles DIGITS-1..k are all zero
    always_comb begin
        lz_run[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_run[k] = lz_run[k+1] & (digits_i[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        nibble   = digits_i[4*sel +: 4];
        lz_blank = lzb_i && (sel != '0) && lz_run[sel];
        dark     = (blink_i[sel] && blink_phase) || (pwm_cnt > bright_i) || lz_blank;
        seg_next = decode(nibble, hex_mode_i);
        an_next  = ~(DIGITS'(1) << sel);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_o        <= '1;
            seg_o       <= SEG_OFF;
            dp_o        <= 1'b1;
            scan_tick_o <= 1'b0;
        end else begin
            scan_tick_o <= scan_end;
            if (dark) begin
                an_o  <= '1;
                seg_o <= SEG_OFF;
                dp_o  <= 1'b1;
            end else begin
                an_o  <= an_next;
                seg_o <= seg_next;
                dp_o  <= ~dp_i[sel];
            end
        end
    end

    // Alarm bank alternates patterns on each blink toggle; the first load after idle is LED_A
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_o <= '0;
        end else if (!alarm_i) begin
            led_o <= '0;
        end else if (blink_end) begin
            led_o <= (led_o == LED_A) ? LED_B : LED_A;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: scan, decode, LZ blanking, blink/dp, brightness, alarm and reset.
module tb_seg_display_mux;

    localparam int DIGITS     = 4;
    localparam int SCAN_DIV   = 4;
    localparam int BLINK_HALF = 16;
    localparam int PWM_BITS   = 2;
    localparam int LED_W      = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [4*DIGITS-1:0]  digits_i;
    logic [DIGITS-1:0]    dp_i;
    logic [DIGITS-1:0]    blink_i;
    logic                 hex_mode_i;
    logic                 lzb_i;
    logic [PWM_BITS-1:0]  bright_i;
    logic                 alarm_i;
    logic [DIGITS-1:0]    an_o;
    logic [6:0]           seg_o;
    logic                 dp_o;
    logic [LED_W-1:0]     led_o;
    logic                 blink_phase_o;
    logic                 scan_tick_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_display_mux #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_HALF(BLINK_HALF),
        .PWM_BITS(PWM_BITS), .LED_W(LED_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i),
        .blink_i(blink_i), .hex_mode_i(hex_mode_i), .lzb_i(lzb_i),
        .bright_i(bright_i), .alarm_i(alarm_i), .an_o(an_o), .seg_o(seg_o),
        .dp_o(dp_o), .led_o(led_o), .blink_phase_o(blink_phase_o),
        .scan_tick_o(scan_tick_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst_n high just after an edge; the next edge is cycle n=0
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_defaults();
        digits_i   = 16'h1234;
        dp_i       = '0;
        blink_i    = '0;
        hex_mode_i = 1'b0;
        lzb_i      = 1'b0;
        bright_i   = 2'd3;
        alarm_i    = 1'b0;
    endtask

    task automatic test_reset();
        set_defaults();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (an_o !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an_o); end
        checks++; if (seg_o !== 7'b1111111) begin failures++; $display("FAIL reset_seg got=%b exp=1111111", seg_o); end
        checks++; if (dp_o !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp_o); end
        checks++; if (led_o !== 16'h0000) begin failures++; $display("FAIL reset_led got=%h exp=0000", led_o); end
        checks++; if (scan_tick_o !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", scan_tick_o); end
        checks++; if (blink_phase_o !== 1'b0) begin failures++; $display("FAIL reset_phase got=%b exp=0", blink_phase_o); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        int         s;
        set_defaults();
        do_reset();
        for (int n = 0; n < 16; n++) begin
            tick();
            s = (n / 4) % 4;
            case (s)
                0:       begin exp_an = 4'b1110; exp_seg = 7'b1001100; end
                1:       begin exp_an = 4'b1101; exp_seg = 7'b0000110; end
                2:       begin exp_an = 4'b1011; exp_seg = 7'b0010010; end
                default: begin exp_an = 4'b0111; exp_seg = 7'b1001111; end
            endcase
            checks++; if (an_o !== exp_an) begin failures++; $display("FAIL scan_an n=%0d got=%b exp=%b", n, an_o, exp_an); end
            checks++; if (seg_o !== exp_seg) begin failures++; $display("FAIL scan_seg n=%0d got=%b exp=%b", n, seg_o, exp_seg); end
            checks++; if (scan_tick_o !== (n % 4 == 3)) begin failures++; $display("FAIL scan_tick n=%0d got=%b exp=%b", n, scan_tick_o, (n % 4 == 3)); end
        end
    endtask

    task automatic test_decode();
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        set_defaults();
        digits_i = 16'h00AF;
        for (int h = 1; h >= 0; h--) begin
            hex_mode_i = (h == 1);
            do_reset();
            for (int n = 0; n < 8; n++) begin
                tick();
                if (n < 4) begin
                    exp_an  = 4'b1110;
                    exp_seg = (h == 1) ? 7'b0111000 : 7'b1111111;
                end else begin
                    exp_an  = 4'b1101;
                    exp_seg = (h == 1) ? 7'b0001000 : 7'b1111111;
                end
                checks++; if (an_o !== exp_an) begin failures++; $display("FAIL decode_an hex=%0d n=%0d got=%b exp=%b", h, n, an_o, exp_an); end
                checks++; if (seg_o !== exp_seg) begin failures++; $display("FAIL decode_seg hex=%0d n=%0d got=%b exp=%b", h, n, seg_o, exp_seg); end
            end
        end
    endtask

    task automatic test_lzb();
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        set_defaults();
        lzb_i    = 1'b1;
        digits_i = 16'h0005;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            tick();
            exp_an  = (n < 4) ? 4'b1110 : 4'b1111;
            exp_seg = (n < 4) ? 7'b0100100 : 7'b1111111;
            checks++; if (an_o !== exp_an) begin failures++; $display("FAIL lzb_an n=%0d got=%b exp=%b", n, an_o, exp_an); end
            checks++; if (seg_o !== exp_seg) begin failures++; $display("FAIL lzb_seg n=%0d got=%b exp=%b", n, seg_o, exp_seg); end
            checks++; if (dp_o !== 1'b1) begin failures++; $display("FAIL lzb_dp n=%0d got=%b exp=1", n, dp_o); end
        end
        digits_i = 16'h0000;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            tick();
            exp_an  = (n < 4) ? 4'b1110 : 4'b1111;
            exp_seg = (n < 4) ? 7'b0000001 : 7'b1111111;
            checks++; if (an_o !== exp_an) begin failures++; $display("FAIL lzb0_an n=%0d got=%b exp=%b", n, an_o, exp_an); end
            checks++; if (seg_o !== exp_seg) begin failures++; $display("FAIL lzb0_seg n=%0d got=%b exp=%b", n, seg_o, exp_seg); end
        end
    endtask

    task automatic test_blink_dp();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic       exp_phase;
        int         s;
        int         ph;
        set_defaults();
        blink_i = 4'b0001;
        dp_i    = 4'b0001;
        do_reset();
        for (int n = 0; n < 64; n++) begin
            tick();
            s         = (n / 4) % 4;
            ph        = (n / 16) % 2;
            exp_phase = (((n + 1) / 16) % 2) == 1;
            case (s)
                0:       begin exp_an = 4'b1110; exp_seg = 7'b1001100; exp_dp = 1'b0; end
                1:       begin exp_an = 4'b1101; exp_seg = 7'b0000110; exp_dp = 1'b1; end
                2:       begin exp_an = 4'b1011; exp_seg = 7'b0010010; exp_dp = 1'b1; end
                default: begin exp_an = 4'b0111; exp_seg = 7'b1001111; exp_dp = 1'b1; end
            endcase
            if (s == 0 && ph == 1) begin
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
                exp_dp  = 1'b1;
            end
            checks++; if (an_o !== exp_an) begin failures++; $display("FAIL blink_an n=%0d got=%b exp=%b", n, an_o, exp_an); end
            checks++; if (seg_o !== exp_seg) begin failures++; $display("FAIL blink_seg n=%0d got=%b exp=%b", n, seg_o, exp_seg); end
            checks++; if (dp_o !== exp_dp) begin failures++; $display("FAIL blink_dp n=%0d got=%b exp=%b", n, dp_o, exp_dp); end
            checks++; if (blink_phase_o !== exp_phase) begin failures++; $display("FAIL blink_phase n=%0d got=%b exp=%b", n, blink_phase_o, exp_phase); end
        end
    endtask

    task automatic test_brightness();
        int  lit_cnt;
        logic exp_lit;
        set_defaults();
        digits_i = 16'h8888;
        for (int b = 0; b < 2; b++) begin
            bright_i = (b == 0) ? 2'd0 : 2'd3;
            lit_cnt  = 0;
            do_reset();
            for (int n = 0; n < 16; n++) begin
                tick();
                exp_lit = (b == 1) || (n % 4 == 0);
                if (an_o != 4'b1111) lit_cnt++;
                checks++; if ((an_o != 4'b1111) !== exp_lit) begin failures++; $display("FAIL bright_lit b=%0d n=%0d got_an=%b exp_lit=%b", b, n, an_o, exp_lit); end
            end
            checks++; if (lit_cnt != ((b == 1) ? 16 : 4)) begin failures++; $display("FAIL bright_count b=%0d got=%0d exp=%0d", b, lit_cnt, (b == 1) ? 16 : 4); end
        end
    endtask

    task automatic test_alarm_reset();
        logic [15:0] exp_led;
        set_defaults();
        alarm_i = 1'b1;
        do_reset();
        for (int n = 0; n < 48; n++) begin
            tick();
            if (n == 14 || n == 15 || n == 30 || n == 31 || n == 46 || n == 47) begin
                case (n)
                    14:      exp_led = 16'h0000;
                    15:      exp_led = 16'hAAAA;
                    30:      exp_led = 16'hAAAA;
                    31:      exp_led = 16'h5555;
                    46:      exp_led = 16'h5555;
                    default: exp_led = 16'hAAAA;
                endcase
                checks++; if (led_o !== exp_led) begin failures++; $display("FAIL alarm_led n=%0d got=%h exp=%h", n, led_o, exp_led); end
            end
        end
        alarm_i = 1'b0;
        tick();
        checks++; if (led_o !== 16'h0000) begin failures++; $display("FAIL alarm_clear got=%h exp=0000", led_o); end
        alarm_i = 1'b1;
        tick();
        tick();
        checks++; if (an_o === 4'b1111) begin failures++; $display("FAIL pre_reset_lit got=%b exp=one_low", an_o); end
        rst_n = 1'b0;
        tick();
        checks++; if (an_o !== 4'b1111) begin failures++; $display("FAIL midreset_an got=%b exp=1111", an_o); end
        checks++; if (seg_o !== 7'b1111111) begin failures++; $display("FAIL midreset_seg got=%b exp=1111111", seg_o); end
        checks++; if (dp_o !== 1'b1) begin failures++; $display("FAIL midreset_dp got=%b exp=1", dp_o); end
        checks++; if (led_o !== 16'h0000) begin failures++; $display("FAIL midreset_led got=%h exp=0000", led_o); end
        checks++; if (scan_tick_o !== 1'b0) begin failures++; $display("FAIL midreset_tick got=%b exp=0", scan_tick_o); end
        checks++; if (blink_phase_o !== 1'b0) begin failures++; $display("FAIL midreset_phase got=%b exp=0", blink_phase_o); end
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++; if (scan_tick_o !== (n == 3)) begin failures++; $display("FAIL restart_tick n=%0d got=%b exp=%b", n, scan_tick_o, (n == 3)); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_defaults();
        test_reset();
        test_scan();
        test_decode();
        test_lzb();
        test_blink_dp();
        test_brightness();
        test_alarm_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Parametrised multiplexed seven-segment driver: scans `DIGITS` common-anode digits from one packed nibble bus, with per-digit blink, decimal points, hex/BCD decode, leading-zero blanking, PWM brightness, and an alternating alarm LED bank. It sits between the counter/timekeeping core and the board pins. It replaces the fixed 4-digit min/sec display driver. All outputs are registered.

## Interface
Parameters:
- `DIGITS`, 4: number of digits, 1..8.
- `SCAN_DIV`, 32768: clk cycles each digit is selected, ≥2.
- `BLINK_HALF`, 16777216: clk cycles per blink half-period, ≥2.
- `PWM_BITS`, 4: brightness resolution.
- `LED_W`, 16: alarm LED bank width, even.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `digits_i`  in  4*DIGITS  nibble k = `digits_i[4k+3:4k]`; digit DIGITS-1 is most significant (leftmost).
- `dp_i`  in  DIGITS  decimal point request per digit, 1 = lit.
- `blink_i`  in  DIGITS  per-digit blink enable.
- `hex_mode_i`  in  1  1 = show A–F; 0 = values 10–15 blank.
- `lzb_i`  in  1  leading-zero blanking enable.
- `bright_i`  in  PWM_BITS  brightness level.
- `alarm_i`  in  1  alarm LED enable.
- `an_o`  out  DIGITS  anodes, active-low, bit k = digit k.
- `seg_o`  out  7  segments {a,b,c,d,e,f,g}, active-low.
- `dp_o`  out  1  decimal point, active-low.
- `led_o`  out  LED_W  alarm LED bank.
- `blink_phase_o`  out  1  current blink phase.
- `scan_tick_o`  out  1  one-cycle pulse at each digit advance.

## Operation
- Scan counter `0..SCAN_DIV-1`. At terminal count it wraps to 0, `sel` advances (DIGITS-1 wraps to 0), and `scan_tick_o`=1 for that cycle.
- Blink counter `0..BLINK_HALF-1`. At terminal count it wraps and `blink_phase` toggles.
- PWM counter (`PWM_BITS` wide) free-runs +1 per cycle and wraps.
- Digit `sel` is dark (anode high, seg/dp all 1) if any of:
  - `blink_i[sel]` and `blink_phase`=1
  - `pwm_cnt > bright_i`
  - leading-zero blanked
- Otherwise, `an_o` has only bit `sel` low.
- Brightness: `bright_i`=0 gives 1/2^PWM_BITS duty; all-ones gives full on.
- Leading-zero blanking: with `lzb_i`=1, digit k≥1 is blanked when nibbles DIGITS-1..k are all zero. Digit 0 is never LZ-blanked. The dp of a blanked digit is also dark.
- Decode, active-low abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - hex_mode_i=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - hex_mode_i=0: 10–15 give 1111111 (anode still driven).
- `dp_o` = ~`dp_i[sel]` when the digit is lit.
- Alarm LEDs: on each `blink_phase` toggle with `alarm_i`=1, `led_o` loads `{LED_W/2{2'b10}}` if the previous value was not that pattern, else `{LED_W/2{2'b01}}`. So the first load after idle is ...1010.
  - `alarm_i`=0 clears `led_o` to 0 on the next cycle, regardless of toggle.

## Timing
- Reset values (rst_n=0 at a clock edge):
  - All counters 0, `sel`=0, `blink_phase`=0.
  - `an_o`=all 1, `seg_o`=7'b1111111, `dp_o`=1.
  - `led_o`=0, `scan_tick_o`=0, `blink_phase_o`=0.
- Reset mid-scan or mid-blink restarts all counters from 0. The first digit advance occurs SCAN_DIV cycles after rst_n rises.
- `an_o`/`seg_o`/`dp_o` are registered: they reflect `sel`, inputs and counters sampled at the previous edge. Latency is one cycle from an input change or `sel` change.
- Frame period = DIGITS·SCAN_DIV cycles. Blink full period = 2·BLINK_HALF cycles.
- Scan, blink and PWM terminals in the same cycle: each acts independently. The output register uses pre-edge values of all three.
- `blink_phase_o` and `led_o` update on the same edge as the toggle.
- DIGITS=1: `sel` stays 0 and `scan_tick_o` still pulses every SCAN_DIV cycles.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, BLINK_HALF=16, PWM_BITS=2, LED_W=16.

- Reset then scan: `digits_i`=16'h1234, all masks 0, `bright_i`=3.
  - `an_o` steps 1110, 1101, 1011, 0111, 4 cycles each.
  - `seg_o` shows 4, 3, 2, 1 patterns.
  - `scan_tick_o` pulses every 4 cycles.
- Decode: `digits_i`=16'h00AF.
  - hex_mode_i=1: digit1 = 0001000, digit0 = 0111000.
  - hex_mode_i=0: both show 1111111.
- LZ blanking: `lzb_i`=1, `digits_i`=16'h0005 → digits 3..1 keep anode high; digit 0 shows 0100100. `digits_i`=16'h0000 → digit 0 shows 0000001.
- Blink and dp: `blink_i`=4'b0001, `dp_i`=4'b0001.
  - Digit 0 is dark for 16-cycle windows while `blink_phase_o`=1, lit with `dp_o`=0 otherwise.
  - Other digits are unaffected.
- Brightness: `bright_i`=0 → any selected anode is low exactly 1 of every 4 cycles. `bright_i`=3 → always low.
- Alarm and reset:
  - `alarm_i`=1 → `led_o` = AAAA, 5555, AAAA on successive blink toggles.
  - Drop `alarm_i` → 0000 the next cycle.
  - Assert rst_n=0 mid-frame → every output at its reset value one edge later.
